// File: rtl/mat_pkg.sv
// Shared types and defaults for the MatInst fetch path.
package mat_pkg;

    typedef enum logic {
        MAT_FETCH_IDLE = 1'b0,
        MAT_FETCH_RUN  = 1'b1
    } MatFetchState_t;

    localparam int MAT_QUEUE_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/mat_fetch_fifo.sv
// Generic synchronous FIFO with flush. DEPTH must be a power of two so the
// pointers wrap naturally. Push while full is accepted only alongside a pop.
module mat_fetch_fifo #(
    parameter  int DEPTH      = 4,
    parameter  int DATA_WIDTH = 8,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output logic [CNT_W-1:0]      count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  do_push, do_pop;

    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
    assign head_data_o = mem_q[rd_ptr_q];

    // A flush cancels any push in the same cycle; a pop is moot once flushed.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && !flush_i && (!full_o || do_pop);

    // Pointer and occupancy tracking.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage; entry 0 is cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mem_q[0] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/mat_inst_fetch_queue.sv
// Instruction prefetch stage: drives the instruction-memory read port from a
// registered pc and queues {addr, word} entries for the controller.
module mat_inst_fetch_queue
    import mat_pkg::*;
#(
    parameter  int INST_MEM_SIZE        = 2048,
    parameter  int INST_MEM_ADDR_SIZE   = 32,
    parameter  int INST_MEM_WIDTH_BYTES = 16,
    parameter  int QUEUE_DEPTH          = MAT_QUEUE_DEPTH_DEFAULT,
    localparam int INST_MEM_WIDTH_SIZE  = 8 * INST_MEM_WIDTH_BYTES,
    localparam int COUNT_SIZE           = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [INST_MEM_ADDR_SIZE-1:0]  start_addr,
    input  logic                           redirect,
    input  logic [INST_MEM_ADDR_SIZE-1:0]  redirect_addr,
    input  logic                           halt,
    output logic [INST_MEM_ADDR_SIZE-1:0]  inst_mem_read_addr,
    input  logic [INST_MEM_WIDTH_SIZE-1:0] inst_mem_data_out,
    output logic                           inst_valid,
    output logic [INST_MEM_WIDTH_SIZE-1:0] inst_data,
    output logic [INST_MEM_ADDR_SIZE-1:0]  inst_addr,
    input  logic                           inst_ready,
    output logic                           running,
    output logic [COUNT_SIZE-1:0]          count
);

    localparam int ENTRY_W = INST_MEM_ADDR_SIZE + INST_MEM_WIDTH_SIZE;
    localparam logic [INST_MEM_ADDR_SIZE-1:0] PC_STRIDE =
        INST_MEM_ADDR_SIZE'(INST_MEM_WIDTH_BYTES);
    localparam logic [INST_MEM_ADDR_SIZE-1:0] PC_LAST =
        INST_MEM_ADDR_SIZE'((INST_MEM_SIZE - 1) * INST_MEM_WIDTH_BYTES);

    MatFetchState_t                  state_q, state_d;
    logic [INST_MEM_ADDR_SIZE-1:0]   pc_q, pc_d;
    logic                            run, pop, fetch, flush;
    logic                            fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]              head;

    assign run   = (state_q == MAT_FETCH_RUN);
    assign pop   = inst_valid && inst_ready;
    // Halt and redirect only matter while fetching; both empty the queue.
    assign flush = run && (halt || redirect);
    assign fetch = run && !halt && !redirect && (!fifo_full || pop);

    assign inst_mem_read_addr = pc_q;
    assign inst_valid         = !fifo_empty;
    assign inst_addr          = head[ENTRY_W-1 -: INST_MEM_ADDR_SIZE];
    assign inst_data          = head[INST_MEM_WIDTH_SIZE-1:0];
    assign running            = run;

    mat_fetch_fifo #(
        .DEPTH      (QUEUE_DEPTH),
        .DATA_WIDTH (ENTRY_W)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (fetch),
        .push_data_i ({pc_q, inst_mem_data_out}),
        .pop_i       (pop),
        .flush_i     (flush),
        .head_data_o (head),
        .count_o     (count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Next-state and pc selection; halt outranks redirect, start only from IDLE.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            MAT_FETCH_IDLE: begin
                if (start) begin
                    state_d = MAT_FETCH_RUN;
                    pc_d    = start_addr;
                end
            end
            MAT_FETCH_RUN: begin
                if (halt) begin
                    state_d = MAT_FETCH_IDLE;
                end else if (redirect) begin
                    pc_d = redirect_addr;
                end else if (fetch) begin
                    pc_d = (pc_q == PC_LAST) ? '0 : pc_q + PC_STRIDE;
                end
            end
            default: state_d = MAT_FETCH_IDLE;
        endcase
    end

    // State and pc registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= MAT_FETCH_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_mat_inst_fetch_queue.sv
// Directed bench for the instruction prefetch queue. Memory model returns
// (addr/16)+100 for any address.
module tb_mat_inst_fetch_queue;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [31:0]  start_addr;
    logic         redirect;
    logic [31:0]  redirect_addr;
    logic         halt;
    logic [31:0]  inst_mem_read_addr;
    logic [127:0] inst_mem_data_out;
    logic         inst_valid;
    logic [127:0] inst_data;
    logic [31:0]  inst_addr;
    logic         inst_ready;
    logic         running;
    logic [2:0]   count;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    assign inst_mem_data_out = {96'd0, (inst_mem_read_addr >> 4) + 32'd100};

    mat_inst_fetch_queue dut (
        .clock              (clock),
        .reset              (reset),
        .start              (start),
        .start_addr         (start_addr),
        .redirect           (redirect),
        .redirect_addr      (redirect_addr),
        .halt               (halt),
        .inst_mem_read_addr (inst_mem_read_addr),
        .inst_mem_data_out  (inst_mem_data_out),
        .inst_valid         (inst_valid),
        .inst_data          (inst_data),
        .inst_addr          (inst_addr),
        .inst_ready         (inst_ready),
        .running            (running),
        .count              (count)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [31:0] addr);
        start = 1'b1; start_addr = addr;
        step();
        start = 1'b0;
    endtask

    task automatic do_halt();
        halt = 1'b1;
        step();
        halt = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 0; start_addr = 0; redirect = 0; redirect_addr = 0;
        halt = 0; inst_ready = 0;
        step(); step();
        reset = 1'b1;
        n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", inst_valid); end
        n_cmp++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running got %0b want 0", running); end
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (inst_mem_read_addr !== 32'd0) begin n_fail++; $display("FAIL reset_rdaddr got %0d want 0", inst_mem_read_addr); end
        n_cmp++; if (inst_data !== 128'd0) begin n_fail++; $display("FAIL reset_data got %0d want 0", inst_data); end
        n_cmp++; if (inst_addr !== 32'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", inst_addr); end
        // redirect/halt in IDLE are ignored
        redirect = 1'b1; redirect_addr = 32'd80; halt = 1'b0;
        step();
        redirect = 1'b0;
        n_cmp++; if (running !== 1'b0 || inst_mem_read_addr !== 32'd0) begin n_fail++; $display("FAIL idle_redirect running=%0b rdaddr=%0d want 0/0", running, inst_mem_read_addr); end
    endtask

    task automatic test_stream();
        inst_ready = 1'b1;
        do_start(32'd0);
        n_cmp++; if (running !== 1'b1 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL stream_c1 running=%0b valid=%0b want 1/0", running, inst_valid); end
        step();
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (inst_valid !== 1'b1 || inst_addr !== 32'(16 * k) || inst_data !== 128'(k + 100)) begin
                n_fail++; $display("FAIL stream k=%0d valid=%0b addr=%0d data=%0d want 1/%0d/%0d", k, inst_valid, inst_addr, inst_data, 16 * k, k + 100);
            end
            // a start while running must be ignored
            start = (k == 3); start_addr = 32'd512;
            step();
        end
        start = 1'b0;
        do_halt();
        n_cmp++; if (running !== 1'b0 || inst_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL stream_halt running=%0b valid=%0b count=%0d want 0/0/0", running, inst_valid, count); end
    endtask

    task automatic test_backpressure();
        inst_ready = 1'b0;
        do_start(32'd0);
        for (int i = 0; i < 6; i++) step();
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL bp_count got %0d want 4", count); end
        n_cmp++; if (inst_mem_read_addr !== 32'd64) begin n_fail++; $display("FAIL bp_pc got %0d want 64", inst_mem_read_addr); end
        n_cmp++; if (inst_valid !== 1'b1 || inst_addr !== 32'd0) begin n_fail++; $display("FAIL bp_head valid=%0b addr=%0d want 1/0", inst_valid, inst_addr); end
        inst_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n_cmp++; if (inst_valid !== 1'b1 || inst_addr !== 32'(16 * k) || inst_data !== 128'(k + 100) || count !== 3'd4) begin
                n_fail++; $display("FAIL bp_drain k=%0d valid=%0b addr=%0d data=%0d count=%0d want 1/%0d/%0d/4", k, inst_valid, inst_addr, inst_data, count, 16 * k, k + 100);
            end
            step();
        end
        do_halt();
    endtask

    task automatic test_redirect();
        inst_ready = 1'b1;
        do_start(32'd0);
        step();
        n_cmp++; if (inst_addr !== 32'd0) begin n_fail++; $display("FAIL redir_pop0 got %0d want 0", inst_addr); end
        step();
        n_cmp++; if (inst_addr !== 32'd16) begin n_fail++; $display("FAIL redir_pop1 got %0d want 16", inst_addr); end
        step();
        redirect = 1'b1; redirect_addr = 32'd80;
        step();
        redirect = 1'b0;
        n_cmp++; if (count !== 3'd0 || inst_valid !== 1'b0 || inst_mem_read_addr !== 32'd80) begin
            n_fail++; $display("FAIL redir_flush count=%0d valid=%0b rdaddr=%0d want 0/0/80", count, inst_valid, inst_mem_read_addr);
        end
        step();
        n_cmp++; if (inst_valid !== 1'b1 || inst_addr !== 32'd80 || inst_data !== 128'd105) begin
            n_fail++; $display("FAIL redir_resume valid=%0b addr=%0d data=%0d want 1/80/105", inst_valid, inst_addr, inst_data);
        end
        step();
        n_cmp++; if (inst_addr !== 32'd96 || inst_data !== 128'd106) begin n_fail++; $display("FAIL redir_next addr=%0d data=%0d want 96/106", inst_addr, inst_data); end
        do_halt();
    endtask

    task automatic test_wrap();
        inst_ready = 1'b1;
        do_start(32'd32752);
        step();
        n_cmp++; if (inst_addr !== 32'd32752 || inst_data !== 128'd2147) begin n_fail++; $display("FAIL wrap_last addr=%0d data=%0d want 32752/2147", inst_addr, inst_data); end
        step();
        n_cmp++; if (inst_addr !== 32'd0 || inst_data !== 128'd100) begin n_fail++; $display("FAIL wrap_zero addr=%0d data=%0d want 0/100", inst_addr, inst_data); end
        step();
        n_cmp++; if (inst_addr !== 32'd16 || inst_data !== 128'd101) begin n_fail++; $display("FAIL wrap_16 addr=%0d data=%0d want 16/101", inst_addr, inst_data); end
        do_halt();
    endtask

    task automatic test_halt_vs_redirect();
        inst_ready = 1'b0;
        do_start(32'd0);
        step(); step();
        n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL hvr_pre count=%0d want 2", count); end
        halt = 1'b1; redirect = 1'b1; redirect_addr = 32'd80;
        step();
        halt = 1'b0; redirect = 1'b0;
        n_cmp++; if (running !== 1'b0 || inst_valid !== 1'b0 || count !== 3'd0) begin
            n_fail++; $display("FAIL hvr_idle running=%0b valid=%0b count=%0d want 0/0/0", running, inst_valid, count);
        end
        step();
        n_cmp++; if (inst_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL hvr_nofetch valid=%0b count=%0d want 0/0", inst_valid, count); end
        inst_ready = 1'b1;
        do_start(32'd32);
        step();
        n_cmp++; if (inst_valid !== 1'b1 || inst_addr !== 32'd32 || inst_data !== 128'd102) begin
            n_fail++; $display("FAIL hvr_restart valid=%0b addr=%0d data=%0d want 1/32/102", inst_valid, inst_addr, inst_data);
        end
        do_halt();
    endtask

    task automatic test_reset_mid();
        inst_ready = 1'b0;
        do_start(32'd0);
        step(); step(); step();
        n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL rst_pre count=%0d want 3", count); end
        reset = 1'b0;
        step();
        reset = 1'b1;
        n_cmp++; if (count !== 3'd0 || running !== 1'b0 || inst_mem_read_addr !== 32'd0 || inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid count=%0d running=%0b rdaddr=%0d valid=%0b want 0/0/0/0", count, running, inst_mem_read_addr, inst_valid);
        end
        n_cmp++; if (inst_data !== 128'd0 || inst_addr !== 32'd0) begin n_fail++; $display("FAIL rst_mid_head data=%0d addr=%0d want 0/0", inst_data, inst_addr); end
        step(); step();
        n_cmp++; if (running !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL rst_stay_idle running=%0b count=%0d want 0/0", running, count); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_halt_vs_redirect();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
